// File: rtl/corefifo_rd_ptr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// corefifo_rd_ptr_ctrl_pkg
// Shared constants and helpers for the COREFIFO pointer controllers.
//   PTRW      : pointer width for the default configuration (ADDRWIDTH+1)
//   DEPTH     : FIFO depth for the default configuration (2^ADDRWIDTH)
//   bin2gray  : binary to reflected-Gray conversion, shared with the
//               write-side controller. Callers cast the result to their
//               own pointer width.
// -----------------------------------------------------------------------------
package corefifo_rd_ptr_ctrl_pkg;

  localparam int ADDRWIDTH_DEF = 3;
  localparam int PTRW          = ADDRWIDTH_DEF + 1;
  localparam int DEPTH         = 1 << ADDRWIDTH_DEF;

  function automatic logic [31:0] bin2gray(input logic [31:0] i_bin);
    return i_bin ^ (i_bin >> 1);
  endfunction

endpackage

// File: rtl/corefifo_rd_ptr_ctrl_gray2bin.sv
// -----------------------------------------------------------------------------
// corefifo_gray2bin
// Combinational Gray-to-binary decoder for an ADDRWIDTH+1 bit pointer.
// Each binary bit is the XOR of all Gray bits from the MSB down to it.
//   i_gray : Gray-coded pointer
//   o_bin  : binary pointer
// -----------------------------------------------------------------------------
module corefifo_gray2bin #(
  parameter int ADDRWIDTH = 3
) (
  input  logic [ADDRWIDTH:0] i_gray,
  output logic [ADDRWIDTH:0] o_bin
);

  always_comb begin
    logic w_run;
    w_run = 1'b0;
    o_bin = '0;
    for (int i = ADDRWIDTH; i >= 0; i--) begin
      w_run    = w_run ^ i_gray[i];
      o_bin[i] = w_run;
    end
  end

endmodule

// File: rtl/corefifo_rd_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// corefifo_rd_ptr_ctrl
// Read-side pointer controller of the dual-clock COREFIFO (read clock domain).
//   clk        : read-domain clock
//   reset      : asynchronous, active-high reset
//   wptr_gray  : write pointer (Gray) from the write domain, asynchronous
//   re         : read request
//   rd_en_mem  : RAM read enable (read accepted this cycle), combinational
//   raddr      : RAM read address, combinational from the read pointer
//   rptr_gray  : registered read pointer (Gray) toward the write domain
//   dvld       : RAM data valid, one cycle after an accepted read
//   empty      : registered empty flag
//   aempty     : registered almost-empty flag (occupancy <= AE_THRESH)
//   rd_count   : registered occupancy seen from the read side
//   underflow  : one-cycle pulse on a read request while empty
//   ptr_err    : sticky flag, occupancy ever exceeded the FIFO depth
// -----------------------------------------------------------------------------
module corefifo_rd_ptr_ctrl
  import corefifo_rd_ptr_ctrl_pkg::*;
#(
  parameter int ADDRWIDTH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDRWIDTH:0]   wptr_gray,
  input  logic                 re,
  output logic                 rd_en_mem,
  output logic [ADDRWIDTH-1:0] raddr,
  output logic [ADDRWIDTH:0]   rptr_gray,
  output logic                 dvld,
  output logic                 empty,
  output logic                 aempty,
  output logic [ADDRWIDTH:0]   rd_count,
  output logic                 underflow,
  output logic                 ptr_err
);

  localparam int L_PTRW  = ADDRWIDTH + 1;
  localparam int L_DEPTH = 1 << ADDRWIDTH;

  localparam logic [L_PTRW-1:0] L_AE_LIM    = L_PTRW'(AE_THRESH);
  localparam logic [L_PTRW-1:0] L_DEPTH_LIM = L_PTRW'(L_DEPTH);

  logic [L_PTRW-1:0] r_wsync1;
  logic [L_PTRW-1:0] r_wsync2;
  logic [L_PTRW-1:0] r_rbin;
  logic [L_PTRW-1:0] r_rptr_gray;
  logic [L_PTRW-1:0] r_rd_count;
  logic              r_dvld;
  logic              r_empty;
  logic              r_aempty;
  logic              r_underflow;
  logic              r_ptr_err;

  logic [L_PTRW-1:0] w_wbin;
  logic              w_acc;
  logic [L_PTRW-1:0] w_rbin_nxt;
  logic [L_PTRW-1:0] w_cnt_nxt;

  corefifo_gray2bin #(
    .ADDRWIDTH(ADDRWIDTH)
  ) u_gray2bin (
    .i_gray(r_wsync2),
    .o_bin (w_wbin)
  );

  // Accept stage: decision uses the registered empty flag, so a read is never
  // accepted in the cycle right after the last word was taken.
  assign w_acc      = re & ~r_empty;
  assign w_rbin_nxt = r_rbin + {{ADDRWIDTH{1'b0}}, w_acc};
  // Modulo subtraction keeps occupancy correct across pointer wrap.
  assign w_cnt_nxt  = w_wbin - w_rbin_nxt;

  assign rd_en_mem  = w_acc;
  assign raddr      = r_rbin[ADDRWIDTH-1:0];

  // Register stage: synchronizer, read pointer and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wsync1    <= '0;
      r_wsync2    <= '0;
      r_rbin      <= '0;
      r_rptr_gray <= '0;
      r_rd_count  <= '0;
      r_dvld      <= 1'b0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_underflow <= 1'b0;
      r_ptr_err   <= 1'b0;
    end else begin
      r_wsync1    <= wptr_gray;
      r_wsync2    <= r_wsync1;
      r_rbin      <= w_rbin_nxt;
      r_rptr_gray <= L_PTRW'(bin2gray(32'(w_rbin_nxt)));
      r_rd_count  <= w_cnt_nxt;
      r_dvld      <= w_acc;
      r_empty     <= (w_cnt_nxt == '0);
      r_aempty    <= (w_cnt_nxt <= L_AE_LIM);
      r_underflow <= re & r_empty;
      r_ptr_err   <= r_ptr_err | (w_cnt_nxt > L_DEPTH_LIM);
    end
  end

  assign rptr_gray = r_rptr_gray;
  assign rd_count  = r_rd_count;
  assign dvld      = r_dvld;
  assign empty     = r_empty;
  assign aempty    = r_aempty;
  assign underflow = r_underflow;
  assign ptr_err   = r_ptr_err;

endmodule

// File: tb/tb_corefifo_rd_ptr_ctrl.sv
module tb_corefifo_rd_ptr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] wptr_gray;
  logic       re;
  logic       rd_en_mem;
  logic [2:0] raddr;
  logic [3:0] rptr_gray;
  logic       dvld;
  logic       empty;
  logic       aempty;
  logic [3:0] rd_count;
  logic       underflow;
  logic       ptr_err;

  corefifo_rd_ptr_ctrl #(.ADDRWIDTH(3), .AE_THRESH(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .wptr_gray(wptr_gray),
    .re       (re),
    .rd_en_mem(rd_en_mem),
    .raddr    (raddr),
    .rptr_gray(rptr_gray),
    .dvld     (dvld),
    .empty    (empty),
    .aempty   (aempty),
    .rd_count (rd_count),
    .underflow(underflow),
    .ptr_err  (ptr_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int wp    = 0;

  // Reference model: write pointer as seen two edges late, read pointer as a
  // plain count of accepted reads, occupancy as their difference mod 16.
  int m_s1, m_s2, m_r, m_cnt;
  bit m_empty, m_aempty, m_dvld, m_uf, m_err;
  bit exp_en;
  int exp_raddr;
  logic       obs_en;
  logic [2:0] obs_raddr;

  wire [12:0] obs_vec = {rptr_gray, rd_count, empty, aempty, dvld, underflow, ptr_err};

  function automatic logic [3:0] g4(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  function automatic logic [12:0] exp_vec();
    return {g4(m_r), 4'(m_cnt), m_empty, m_aempty, m_dvld, m_uf, m_err};
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_r = 0; m_cnt = 0;
    m_empty = 1; m_aempty = 1; m_dvld = 0; m_uf = 0; m_err = 0;
  endtask

  // Drive one cycle, snapshot the combinational outputs, advance the model.
  task automatic step(input bit re_v, input int wb);
    int nr;
    re        = re_v;
    wptr_gray = g4(wb);
    #1;
    exp_en    = re_v && !m_empty;
    exp_raddr = m_r & 7;
    obs_en    = rd_en_mem;
    obs_raddr = raddr;
    @(posedge clk);
    #1;
    nr      = (m_r + (exp_en ? 1 : 0)) & 15;
    m_cnt   = (m_s2 - nr) & 15;
    m_uf    = re_v && m_empty;
    m_dvld  = exp_en;
    m_s2    = m_s1;
    m_s1    = wb & 15;
    m_r     = nr;
    m_empty = (m_cnt == 0);
    m_aempty = (m_cnt <= 1);
    if (m_cnt > 8) m_err = 1;
  endtask

  task automatic assert_reset();
    #2;
    reset     = 1'b1;
    re        = 1'b0;
    wptr_gray = 4'b0000;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    wp    = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(0, 5);
    step(1, 5);
    n_vec++;
    if (obs_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_pre: got %b expected %b", obs_vec, exp_vec());
    end
    assert_reset();
    n_vec++;
    if (obs_vec !== 13'b0000_0000_1_1_0_0_0) begin
      n_err++;
      $display("FAIL reset_async: got %b expected %b", obs_vec, 13'b0000_0000_1_1_0_0_0);
    end
    release_reset();
    n_vec++;
    if (obs_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_release: got %b expected %b", obs_vec, exp_vec());
    end
  endtask

  task automatic test_fill();
    wp = 3;
    for (int i = 0; i < 3; i++) begin
      step(0, wp);
      n_vec++;
      if (obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL fill_model[%0d]: got %b expected %b", i, obs_vec, exp_vec());
      end
      n_vec++;
      if ({rd_count, empty, aempty} !== ((i < 2) ? 6'b0000_1_1 : 6'b0011_0_0)) begin
        n_err++;
        $display("FAIL fill_flags[%0d]: got cnt=%0d e=%b ae=%b", i, rd_count, empty, aempty);
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      step(1, wp);
      n_vec++;
      if (obs_en !== (i < 3) || (i < 3 && obs_raddr !== i[2:0])) begin
        n_err++;
        $display("FAIL drain_accept[%0d]: got en=%b addr=%0d expected en=%b addr=%0d",
                 i, obs_en, obs_raddr, (i < 3), i);
      end
      n_vec++;
      if (dvld !== (i < 3) || underflow !== (i == 3) || empty !== (i >= 2)) begin
        n_err++;
        $display("FAIL drain_flags[%0d]: got dvld=%b uf=%b e=%b", i, dvld, underflow, empty);
      end
      n_vec++;
      if (obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL drain_model[%0d]: got %b expected %b", i, obs_vec, exp_vec());
      end
    end
    n_vec++;
    if (rptr_gray !== 4'b0010) begin
      n_err++;
      $display("FAIL drain_rptr: got %b expected 0010", rptr_gray);
    end
    step(0, wp);
    n_vec++;
    if (underflow !== 1'b0 || dvld !== 1'b0) begin
      n_err++;
      $display("FAIL drain_idle: got uf=%b dvld=%b expected 0 0", underflow, dvld);
    end
  endtask

  task automatic test_wrap();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      wp = (m_r >= 7) ? 15 : 11;
      step(1, wp);
      n_vec++;
      if (obs_vec !== exp_vec() || obs_en !== exp_en) begin
        n_err++;
        $display("FAIL wrap_run[%0d]: got %b en=%b expected %b en=%b",
                 i, obs_vec, obs_en, exp_vec(), exp_en);
      end
      if (m_r == 15 && m_empty) done = 1;
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL wrap_timeout: got rbin=%0d expected 15", m_r);
    end
    wp = 0;
    for (int i = 0; i < 3; i++) step(0, wp);
    n_vec++;
    if (rd_count !== 4'd1 || rptr_gray !== 4'b1000) begin
      n_err++;
      $display("FAIL wrap_before: got cnt=%0d rptr=%b expected 1 1000", rd_count, rptr_gray);
    end
    step(1, wp);
    n_vec++;
    if (obs_en !== 1'b1 || obs_raddr !== 3'd7) begin
      n_err++;
      $display("FAIL wrap_addr: got en=%b addr=%0d expected 1 7", obs_en, obs_raddr);
    end
    n_vec++;
    if (rd_count !== 4'd0 || rptr_gray !== 4'b0000 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_after: got cnt=%0d rptr=%b e=%b expected 0 0000 1",
               rd_count, rptr_gray, empty);
    end
  endtask

  task automatic test_simultaneous();
    wp = 1;
    for (int i = 0; i < 3; i++) step(0, wp);
    n_vec++;
    if (rd_count !== 4'd1) begin
      n_err++;
      $display("FAIL simul_setup: got cnt=%0d expected 1", rd_count);
    end
    wp = 2;
    step(0, wp);
    step(0, wp);
    step(1, wp);
    n_vec++;
    if (obs_en !== 1'b1) begin
      n_err++;
      $display("FAIL simul_accept: got en=%b expected 1", obs_en);
    end
    n_vec++;
    if (rd_count !== 4'd1 || empty !== 1'b0 || underflow !== 1'b0) begin
      n_err++;
      $display("FAIL simul_flags: got cnt=%0d e=%b uf=%b expected 1 0 0",
               rd_count, empty, underflow);
    end
    n_vec++;
    if (obs_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL simul_model: got %b expected %b", obs_vec, exp_vec());
    end
  endtask

  task automatic test_ptr_err();
    assert_reset();
    release_reset();
    wp = 9;
    for (int i = 0; i < 3; i++) begin
      step(0, wp);
      n_vec++;
      if (ptr_err !== (i == 2)) begin
        n_err++;
        $display("FAIL perr_set[%0d]: got %b expected %b", i, ptr_err, (i == 2));
      end
    end
    wp = 2;
    for (int i = 0; i < 4; i++) begin
      step(0, wp);
      n_vec++;
      if (ptr_err !== 1'b1 || obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL perr_hold[%0d]: got %b expected %b", i, obs_vec, exp_vec());
      end
    end
    assert_reset();
    n_vec++;
    if (ptr_err !== 1'b0) begin
      n_err++;
      $display("FAIL perr_clear: got %b expected 0", ptr_err);
    end
    release_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0 && (((wp + 1) - m_r) & 15) <= 8)
        wp = (wp + 1) & 15;
      step(bit'($urandom_range(0, 1)), wp);
      n_vec++;
      if (obs_en !== exp_en || (exp_en && obs_raddr !== 3'(exp_raddr))) begin
        n_err++;
        $display("FAIL rand_accept[%0d]: got en=%b addr=%0d expected en=%b addr=%0d",
                 i, obs_en, obs_raddr, exp_en, exp_raddr);
      end
      n_vec++;
      if (obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL rand_regs[%0d]: got %b expected %b", i, obs_vec, exp_vec());
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    re        = 1'b0;
    wptr_gray = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_ptr_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
